io_word_bridge: RTL and testbench

IO_WORD_BRIDGE -- requirements
Module: io_word_bridge

---
 rtl/io_bridge_pkg.sv | 31 +++
 rtl/io_word_bridge.sv | 159 +++++++++++++++
 tb/tb_io_word_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bridge_pkg.sv
// Shared state encodings, transfer size codes and lane helpers for the
// byte <-> word IO bridge.
package io_bridge_pkg;

  typedef enum logic {
    IN_IDLE    = 1'b0,
    IN_COLLECT = 1'b1
  } in_state_t;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_SEND = 1'b1
  } out_state_t;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  // Byte transfers always live in bits [7:0]; word lanes follow the wire order.
  function automatic logic [1:0] lane_of(input logic big_endian,
                                         input logic size,
                                         input logic [1:0] cnt);
    if (size == SZ_BYTE)
      return 2'd0;
    return big_endian ? ~cnt : cnt;
  endfunction

  function automatic logic is_last(input logic size, input logic [1:0] cnt);
    return (size == SZ_BYTE) || (cnt == 2'd3);
  endfunction

endpackage

// File: rtl/io_word_bridge.sv
// Bridges a byte-wide UART-side controller to CPU byte/word IO requests,
// with independent input (assemble) and output (serialise) paths.
module io_word_bridge
  import io_bridge_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_byte_vld,
  output logic        in_byte_rdy,
  output logic [7:0]  out_byte,
  output logic        out_byte_vld,
  input  logic        out_byte_rdy,
  input  logic        cpu_in_req,
  input  logic        cpu_in_size,
  output logic [31:0] cpu_in_data,
  output logic        cpu_in_done,
  input  logic        cpu_out_req,
  input  logic        cpu_out_size,
  input  logic [31:0] cpu_out_data,
  output logic        cpu_out_done
);

  in_state_t   in_state, in_state_nxt;
  logic        in_size;
  logic [1:0]  in_cnt;
  logic [1:0]  in_lane;
  logic [31:0] in_shift;
  logic [31:0] in_merged;
  logic        in_start, in_xfer, in_last;

  out_state_t  out_state, out_state_nxt;
  logic        out_size;
  logic [1:0]  out_cnt;
  logic [1:0]  out_lane;
  logic [31:0] out_data;
  logic        out_start, out_xfer, out_last;

  // ---------------- input path ----------------
  always_ff @(posedge clk) begin
    if (rst)
      in_state <= IN_IDLE;
    else
      in_state <= in_state_nxt;
  end

  // A request overlapping the done pulse is dropped so the CPU sees the result first.
  always_comb begin
    in_state_nxt = in_state;
    in_byte_rdy  = 1'b0;
    in_start     = 1'b0;
    in_xfer      = 1'b0;
    in_last      = 1'b0;
    case (in_state)
      IN_IDLE: begin
        in_start = cpu_in_req && !cpu_in_done;
        if (in_start)
          in_state_nxt = IN_COLLECT;
      end
      IN_COLLECT: begin
        in_byte_rdy = 1'b1;
        in_xfer     = in_byte_vld;
        in_last     = in_xfer && is_last(in_size, in_cnt);
        if (in_last)
          in_state_nxt = IN_IDLE;
      end
      default: in_state_nxt = IN_IDLE;
    endcase
  end

  assign in_lane = lane_of(BIG_ENDIAN, in_size, in_cnt);

  always_comb begin
    in_merged = in_shift;
    in_merged[{in_lane, 3'b000} +: 8] = in_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_size     <= SZ_BYTE;
      in_cnt      <= 2'd0;
      in_shift    <= 32'h0;
      cpu_in_data <= 32'h0;
      cpu_in_done <= 1'b0;
    end else begin
      cpu_in_done <= in_last;
      if (in_start) begin
        in_size  <= cpu_in_size;
        in_cnt   <= 2'd0;
        in_shift <= 32'h0;
      end else if (in_xfer) begin
        in_shift <= in_merged;
        in_cnt   <= in_last ? 2'd0 : in_cnt + 2'd1;
        if (in_last)
          cpu_in_data <= in_merged;
      end
    end
  end

  // ---------------- output path ----------------
  always_ff @(posedge clk) begin
    if (rst)
      out_state <= OUT_IDLE;
    else
      out_state <= out_state_nxt;
  end

  always_comb begin
    out_state_nxt = out_state;
    out_byte_vld  = 1'b0;
    out_start     = 1'b0;
    out_xfer      = 1'b0;
    out_last      = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        out_start = cpu_out_req && !cpu_out_done;
        if (out_start)
          out_state_nxt = OUT_SEND;
      end
      OUT_SEND: begin
        out_byte_vld = 1'b1;
        out_xfer     = out_byte_rdy;
        out_last     = out_xfer && is_last(out_size, out_cnt);
        if (out_last)
          out_state_nxt = OUT_IDLE;
      end
      default: out_state_nxt = OUT_IDLE;
    endcase
  end

  assign out_lane = lane_of(BIG_ENDIAN, out_size, out_cnt);

  always_comb begin
    out_byte = 8'h00;
    if (out_state == OUT_SEND)
      out_byte = out_data[{out_lane, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_size     <= SZ_BYTE;
      out_cnt      <= 2'd0;
      out_data     <= 32'h0;
      cpu_out_done <= 1'b0;
    end else begin
      cpu_out_done <= out_last;
      if (out_start) begin
        out_size <= cpu_out_size;
        out_cnt  <= 2'd0;
        out_data <= cpu_out_data;
      end else if (out_xfer) begin
        out_cnt <= out_last ? 2'd0 : out_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_io_word_bridge.sv
// Directed bench: little- and big-endian bridges share every input so each
// scenario checks both lane orders side by side.
module tb_io_word_bridge;

  logic        clk;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_byte_vld;
  logic        out_byte_rdy;
  logic        cpu_in_req;
  logic        cpu_in_size;
  logic        cpu_out_req;
  logic        cpu_out_size;
  logic [31:0] cpu_out_data;

  logic        in_byte_rdy_le, in_byte_rdy_be;
  logic [7:0]  out_byte_le, out_byte_be;
  logic        out_byte_vld_le, out_byte_vld_be;
  logic [31:0] cpu_in_data_le, cpu_in_data_be;
  logic        cpu_in_done_le, cpu_in_done_be;
  logic        cpu_out_done_le, cpu_out_done_be;

  int n_cmp = 0;
  int n_err = 0;

  io_word_bridge #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst),
    .in_byte(in_byte), .in_byte_vld(in_byte_vld), .in_byte_rdy(in_byte_rdy_le),
    .out_byte(out_byte_le), .out_byte_vld(out_byte_vld_le), .out_byte_rdy(out_byte_rdy),
    .cpu_in_req(cpu_in_req), .cpu_in_size(cpu_in_size),
    .cpu_in_data(cpu_in_data_le), .cpu_in_done(cpu_in_done_le),
    .cpu_out_req(cpu_out_req), .cpu_out_size(cpu_out_size),
    .cpu_out_data(cpu_out_data), .cpu_out_done(cpu_out_done_le)
  );

  io_word_bridge #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst),
    .in_byte(in_byte), .in_byte_vld(in_byte_vld), .in_byte_rdy(in_byte_rdy_be),
    .out_byte(out_byte_be), .out_byte_vld(out_byte_vld_be), .out_byte_rdy(out_byte_rdy),
    .cpu_in_req(cpu_in_req), .cpu_in_size(cpu_in_size),
    .cpu_in_data(cpu_in_data_be), .cpu_in_done(cpu_in_done_be),
    .cpu_out_req(cpu_out_req), .cpu_out_size(cpu_out_size),
    .cpu_out_data(cpu_out_data), .cpu_out_done(cpu_out_done_be)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and waits (bounded) until it is taken by the bridge.
  task automatic push_byte(input logic [7:0] b);
    int waited = 0;
    in_byte     = b;
    in_byte_vld = 1'b1;
    while (!(in_byte_rdy_le && in_byte_rdy_be) && waited < 20) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (!(in_byte_rdy_le && in_byte_rdy_be)) begin
      n_err++;
      $display("[TB] FAIL push_byte_rdy: got rdy_le=%0b rdy_be=%0b, want 1/1", in_byte_rdy_le, in_byte_rdy_be);
    end
    tick();
    in_byte_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_byte = 8'h00; in_byte_vld = 1'b0; out_byte_rdy = 1'b0;
    cpu_in_req = 1'b0; cpu_in_size = 1'b0;
    cpu_out_req = 1'b0; cpu_out_size = 1'b0; cpu_out_data = 32'h0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_byte_rdy_le, in_byte_rdy_be, out_byte_vld_le, out_byte_vld_be} !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL reset_handshake: got %b, want 0000",
               {in_byte_rdy_le, in_byte_rdy_be, out_byte_vld_le, out_byte_vld_be});
    end
    n_cmp++;
    if ({cpu_in_done_le, cpu_in_done_be, cpu_out_done_le, cpu_out_done_be} !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL reset_done: got %b, want 0000",
               {cpu_in_done_le, cpu_in_done_be, cpu_out_done_le, cpu_out_done_be});
    end
    n_cmp++;
    if (cpu_in_data_le !== 32'h0 || cpu_in_data_be !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL reset_data: got %h/%h, want 0", cpu_in_data_le, cpu_in_data_be);
    end
    in_byte = 8'h99; in_byte_vld = 1'b1;
    tick(); tick();
    n_cmp++;
    if (in_byte_rdy_le !== 1'b0 || in_byte_rdy_be !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL idle_no_consume: got rdy %b%b, want 00", in_byte_rdy_le, in_byte_rdy_be);
    end
    in_byte_vld = 1'b0;
  endtask

  task automatic test_word_read();
    cpu_in_req = 1'b1; cpu_in_size = 1'b1;
    tick();
    cpu_in_req = 1'b0;
    push_byte(8'h78); push_byte(8'h56); push_byte(8'h34); push_byte(8'h12);
    n_cmp++;
    if (cpu_in_done_le !== 1'b1 || cpu_in_done_be !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL word_read_done: got %b%b, want 11", cpu_in_done_le, cpu_in_done_be);
    end
    n_cmp++;
    if (cpu_in_data_le !== 32'h12345678 || cpu_in_data_be !== 32'h78563412) begin
      n_err++;
      $display("[TB] FAIL word_read_data: got %h/%h, want 12345678/78563412", cpu_in_data_le, cpu_in_data_be);
    end
    n_cmp++;
    if (in_byte_rdy_le !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL word_read_rdy_after: got %b, want 0", in_byte_rdy_le);
    end
    tick();
    n_cmp++;
    if (cpu_in_done_le !== 1'b0 || cpu_in_data_le !== 32'h12345678) begin
      n_err++;
      $display("[TB] FAIL word_read_hold: got done=%b data=%h, want 0/12345678", cpu_in_done_le, cpu_in_data_le);
    end
  endtask

  task automatic test_byte_read();
    cpu_in_req = 1'b1; cpu_in_size = 1'b0;
    tick();
    cpu_in_req = 1'b0;
    push_byte(8'hA5);
    n_cmp++;
    if (cpu_in_done_le !== 1'b1 || cpu_in_data_le !== 32'h000000A5 || cpu_in_data_be !== 32'h000000A5) begin
      n_err++;
      $display("[TB] FAIL byte_read: got done=%b data=%h/%h, want 1/000000a5/000000a5",
               cpu_in_done_le, cpu_in_data_le, cpu_in_data_be);
    end
    in_byte = 8'h3C; in_byte_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (in_byte_rdy_le !== 1'b0 || in_byte_rdy_be !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL byte_unconsumed[%0d]: got rdy %b%b, want 00", i, in_byte_rdy_le, in_byte_rdy_be);
      end
    end
    cpu_in_req = 1'b1;
    tick();
    cpu_in_req = 1'b0;
    tick();
    in_byte_vld = 1'b0;
    n_cmp++;
    if (cpu_in_done_le !== 1'b1 || cpu_in_data_le !== 32'h0000003C || cpu_in_data_be !== 32'h0000003C) begin
      n_err++;
      $display("[TB] FAIL byte_read_second: got done=%b data=%h/%h, want 1/0000003c/0000003c",
               cpu_in_done_le, cpu_in_data_le, cpu_in_data_be);
    end
    tick();
  endtask

  task automatic test_word_write();
    logic [31:0] word;
    logic [7:0]  exp_le, exp_be;
    word = 32'hDEADBEEF;
    cpu_out_req = 1'b1; cpu_out_size = 1'b1; cpu_out_data = word;
    out_byte_rdy = 1'b0;
    tick();
    cpu_out_req = 1'b0; cpu_out_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      exp_le = word[8*k +: 8];
      exp_be = word[8*(3-k) +: 8];
      out_byte_rdy = 1'b0;
      tick();
      n_cmp++;
      if (out_byte_vld_le !== 1'b1 || out_byte_vld_be !== 1'b1 ||
          out_byte_le !== exp_le || out_byte_be !== exp_be) begin
        n_err++;
        $display("[TB] FAIL write_hold[%0d]: got vld=%b%b bytes=%h/%h, want 11 %h/%h",
                 k, out_byte_vld_le, out_byte_vld_be, out_byte_le, out_byte_be, exp_le, exp_be);
      end
      out_byte_rdy = 1'b1;
      tick();
    end
    out_byte_rdy = 1'b0;
    n_cmp++;
    if (out_byte_vld_le !== 1'b0 || cpu_out_done_le !== 1'b1 || cpu_out_done_be !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL write_done: got vld=%b done=%b%b, want 0 11",
               out_byte_vld_le, cpu_out_done_le, cpu_out_done_be);
    end
    tick();
    n_cmp++;
    if (cpu_out_done_le !== 1'b0 || out_byte_vld_be !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL write_done_once: got done=%b vld=%b, want 0 0", cpu_out_done_le, out_byte_vld_be);
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] rd_word, wr_word;
    int          in_dones, out_dones;
    rd_word = 32'hCAFEF00D;
    wr_word = 32'h01234567;
    cpu_in_req = 1'b1; cpu_in_size = 1'b1;
    cpu_out_req = 1'b1; cpu_out_size = 1'b1; cpu_out_data = wr_word;
    tick();
    cpu_in_req = 1'b0; cpu_out_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_byte = rd_word[8*k +: 8]; in_byte_vld = 1'b1; out_byte_rdy = 1'b1;
      n_cmp++;
      if (out_byte_le !== wr_word[8*k +: 8] || out_byte_be !== wr_word[8*(3-k) +: 8] ||
          in_byte_rdy_le !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL concurrent_lane[%0d]: got out=%h/%h rdy=%b", k, out_byte_le, out_byte_be, in_byte_rdy_le);
      end
      tick();
    end
    in_byte_vld = 1'b0; out_byte_rdy = 1'b0;
    n_cmp++;
    if (cpu_in_data_le !== 32'hCAFEF00D || cpu_in_data_be !== 32'h0DF0FECA) begin
      n_err++;
      $display("[TB] FAIL concurrent_read: got %h/%h, want cafef00d/0df0feca", cpu_in_data_le, cpu_in_data_be);
    end
    in_dones = 0; out_dones = 0;
    for (int i = 0; i < 4; i++) begin
      in_dones  += int'(cpu_in_done_le);
      out_dones += int'(cpu_out_done_le);
      if (i < 3) tick();
    end
    n_cmp++;
    if (in_dones != 1 || out_dones != 1) begin
      n_err++;
      $display("[TB] FAIL concurrent_dones: got in=%0d out=%0d, want 1/1", in_dones, out_dones);
    end
  endtask

  task automatic test_reset_mid();
    cpu_in_req = 1'b1; cpu_in_size = 1'b1;
    cpu_out_req = 1'b1; cpu_out_size = 1'b1; cpu_out_data = 32'hA1B2C3D4;
    tick();
    cpu_in_req = 1'b0; cpu_out_req = 1'b0;
    push_byte(8'hAA);
    push_byte(8'hBB);
    rst = 1'b1; in_byte = 8'hCC; in_byte_vld = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (cpu_in_done_le !== 1'b0 || in_byte_rdy_le !== 1'b0 || out_byte_vld_le !== 1'b0 ||
        cpu_out_done_le !== 1'b0 || cpu_in_data_le !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL reset_mid_state: got done=%b rdy=%b vld=%b odone=%b data=%h, want 0 0 0 0 0",
               cpu_in_done_le, in_byte_rdy_le, out_byte_vld_le, cpu_out_done_le, cpu_in_data_le);
    end
    tick();
    n_cmp++;
    if (in_byte_rdy_le !== 1'b0 || cpu_in_done_le !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_mid_idle: got rdy=%b done=%b, want 0 0", in_byte_rdy_le, cpu_in_done_le);
    end
    in_byte_vld = 1'b0;
    cpu_in_req = 1'b1; cpu_in_size = 1'b1;
    tick();
    cpu_in_req = 1'b0;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    n_cmp++;
    if (cpu_in_done_le !== 1'b1 || cpu_in_data_le !== 32'h04030201 || cpu_in_data_be !== 32'h01020304) begin
      n_err++;
      $display("[TB] FAIL reset_mid_reread: got done=%b data=%h/%h, want 1/04030201/01020304",
               cpu_in_done_le, cpu_in_data_le, cpu_in_data_be);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int          idx, dones, gap;
    logic        xfer;
    logic [31:0] d_le [2];
    logic [31:0] d_be [2];
    idx = 0; dones = 0; gap = 0;
    d_le[0] = 32'h0; d_le[1] = 32'h0; d_be[0] = 32'h0; d_be[1] = 32'h0;
    cpu_in_req = 1'b1; cpu_in_size = 1'b1;
    for (int c = 0; c < 60 && dones < 2; c++) begin
      in_byte     = 8'h10 + 8'(idx);
      in_byte_vld = (idx < 8);
      xfer = in_byte_rdy_le && in_byte_vld;
      tick();
      if (xfer) idx++;
      if (cpu_in_done_le) begin
        d_le[dones] = cpu_in_data_le;
        d_be[dones] = cpu_in_data_be;
        dones++;
        if (dones == 2) cpu_in_req = 1'b0;
      end
      if (dones == 1 && idx == 4 && !in_byte_rdy_le) gap++;
    end
    cpu_in_req = 1'b0; in_byte_vld = 1'b0;
    n_cmp++;
    if (dones != 2 || idx != 8) begin
      n_err++;
      $display("[TB] FAIL b2b_count: got dones=%0d bytes=%0d, want 2/8", dones, idx);
    end
    n_cmp++;
    if (d_le[0] !== 32'h13121110 || d_le[1] !== 32'h17161514) begin
      n_err++;
      $display("[TB] FAIL b2b_data_le: got %h %h, want 13121110 17161514", d_le[0], d_le[1]);
    end
    n_cmp++;
    if (d_be[0] !== 32'h10111213 || d_be[1] !== 32'h14151617) begin
      n_err++;
      $display("[TB] FAIL b2b_data_be: got %h %h, want 10111213 14151617", d_be[0], d_be[1]);
    end
    n_cmp++;
    if (gap != 2) begin
      n_err++;
      $display("[TB] FAIL b2b_idle_gap: got %0d idle cycles, want 2", gap);
    end
    in_byte = 8'h55; in_byte_vld = 1'b1;
    tick(); tick();
    n_cmp++;
    if (in_byte_rdy_le !== 1'b0 || cpu_in_data_le !== 32'h17161514) begin
      n_err++;
      $display("[TB] FAIL b2b_quiet: got rdy=%b data=%h, want 0/17161514", in_byte_rdy_le, cpu_in_data_le);
    end
    in_byte_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_read();
    test_word_write();
    test_concurrent();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
